rx_session_ctrl: RTL

//  Per-packet sequencer for the dot11 receive core. Tracks each reception from demod start through

---
 rtl/rx_session_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_session_ctrl.sv
// Per-packet receive sequencer: tracks header, payload bytes and FCS, enforces limits,
// and issues a timed receiver_rst pulse whenever a reception is aborted or times out.
module rx_session_ctrl #(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMER_W    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               sample_in_strobe,
    input  logic               demod_is_ongoing,
    input  logic               pkt_header_valid,
    input  logic               pkt_header_valid_strobe,
    input  logic [15:0]        pkt_len,
    input  logic               byte_out_strobe,
    input  logic               fcs_out_strobe,
    input  logic               fcs_ok,
    input  logic               ext_rst_req,
    input  logic [15:0]        max_pkt_len,
    input  logic [TIMER_W-1:0] hdr_timeout_samp,
    input  logic [TIMER_W-1:0] byte_timeout_samp,
    output logic               receiver_rst,
    output logic               rx_busy,
    output logic               pkt_done_stb,
    output logic [1:0]         pkt_status,
    output logic [CNT_W-1:0]   cnt_ok,
    output logic [CNT_W-1:0]   cnt_fcs_err,
    output logic [CNT_W-1:0]   cnt_abort,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWaitHdr = 3'd1,
        StRecv    = 3'd2,
        StWaitFcs = 3'd3,
        StRst     = 3'd4
    } state_e;

    localparam logic [1:0] StatOk      = 2'd0;
    localparam logic [1:0] StatFcsErr  = 2'd1;
    localparam logic [1:0] StatTimeout = 2'd2;
    localparam logic [1:0] StatAbort   = 2'd3;

    localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYCLES - 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [15:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]          len_q, len_d;
    logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
    logic                 receiver_rst_q, receiver_rst_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 pkt_done_stb_q, pkt_done_stb_d;
    logic [1:0]           pkt_status_q, pkt_status_d;
    logic [CNT_W-1:0]     cnt_ok_q, cnt_ok_d;
    logic [CNT_W-1:0]     cnt_fcs_err_q, cnt_fcs_err_d;
    logic [CNT_W-1:0]     cnt_abort_q, cnt_abort_d;

    logic                 done;
    logic [1:0]           status;
    logic                 byte_acc;
    logic                 hdr_to;
    logic                 byte_to;
    logic                 hdr_ok;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        done       = 1'b0;
        status     = StatOk;
        byte_acc   = 1'b0;
        hdr_to     = (timer_q >= hdr_timeout_samp);
        byte_to    = (timer_q >= byte_timeout_samp);
        hdr_ok     = pkt_header_valid && (pkt_len != 16'd0) && (pkt_len <= max_pkt_len);

        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ext_rst_req) begin
                        state_d = StRst;
                    end else if (demod_is_ongoing) begin
                        state_d = StWaitHdr;
                    end
                end
                StWaitHdr: begin
                    if (ext_rst_req) begin
                        done   = 1'b1;
                        status = StatAbort;
                    end else if (pkt_header_valid_strobe) begin
                        if (hdr_ok) begin
                            len_d      = pkt_len;
                            byte_cnt_d = 16'd0;
                            state_d    = StRecv;
                        end else begin
                            done   = 1'b1;
                            status = StatAbort;
                        end
                    end else if (hdr_to) begin
                        done   = 1'b1;
                        status = StatTimeout;
                    end else if (!demod_is_ongoing) begin
                        state_d = StIdle;
                    end
                end
                StRecv: begin
                    if (ext_rst_req) begin
                        done   = 1'b1;
                        status = StatAbort;
                    end else begin
                        if (byte_out_strobe) begin
                            byte_acc   = 1'b1;
                            byte_cnt_d = byte_cnt_q + 16'd1;
                        end
                        if (fcs_out_strobe) begin
                            done   = 1'b1;
                            status = fcs_ok ? StatOk : StatFcsErr;
                        end else if (byte_out_strobe) begin
                            if (byte_cnt_d == len_q) begin
                                state_d = StWaitFcs;
                            end
                        end else if (byte_to) begin
                            done   = 1'b1;
                            status = StatTimeout;
                        end
                    end
                end
                StWaitFcs: begin
                    if (ext_rst_req) begin
                        done   = 1'b1;
                        status = StatAbort;
                    end else if (fcs_out_strobe) begin
                        done   = 1'b1;
                        status = fcs_ok ? StatOk : StatFcsErr;
                    end else if (byte_to) begin
                        done   = 1'b1;
                        status = StatTimeout;
                    end
                end
                StRst: begin
                    if (rst_cnt_q == RstLast) begin
                        state_d = StIdle;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Timeouts and aborts both recover through the reset pulse; good packets do not.
        if (done) begin
            state_d = status[1] ? StRst : StIdle;
        end
        if ((state_d == StRst) && (state_q != StRst)) begin
            rst_cnt_d = '0;
        end

        timer_d = timer_q;
        if ((state_d != state_q) || byte_acc) begin
            timer_d = '0;
        end else if (sample_in_strobe && (timer_q != {TIMER_W{1'b1}})) begin
            timer_d = timer_q + 1'b1;
        end

        cnt_ok_d      = cnt_ok_q;
        cnt_fcs_err_d = cnt_fcs_err_q;
        cnt_abort_d   = cnt_abort_q;
        if (done) begin
            if (status == StatOk) begin
                if (cnt_ok_q != {CNT_W{1'b1}}) cnt_ok_d = cnt_ok_q + 1'b1;
            end else if (status == StatFcsErr) begin
                if (cnt_fcs_err_q != {CNT_W{1'b1}}) cnt_fcs_err_d = cnt_fcs_err_q + 1'b1;
            end else begin
                if (cnt_abort_q != {CNT_W{1'b1}}) cnt_abort_d = cnt_abort_q + 1'b1;
            end
        end

        receiver_rst_d = (state_d == StRst);
        rx_busy_d      = (state_d == StWaitHdr) || (state_d == StRecv) || (state_d == StWaitFcs);
        pkt_done_stb_d = done;
        pkt_status_d   = done ? status : pkt_status_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            byte_cnt_q     <= '0;
            len_q          <= '0;
            rst_cnt_q      <= '0;
            receiver_rst_q <= 1'b0;
            rx_busy_q      <= 1'b0;
            pkt_done_stb_q <= 1'b0;
            pkt_status_q   <= 2'd0;
            cnt_ok_q       <= '0;
            cnt_fcs_err_q  <= '0;
            cnt_abort_q    <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            rst_cnt_q      <= rst_cnt_d;
            receiver_rst_q <= receiver_rst_d;
            rx_busy_q      <= rx_busy_d;
            pkt_done_stb_q <= pkt_done_stb_d;
            pkt_status_q   <= pkt_status_d;
            cnt_ok_q       <= cnt_ok_d;
            cnt_fcs_err_q  <= cnt_fcs_err_d;
            cnt_abort_q    <= cnt_abort_d;
        end
    end

    assign receiver_rst = receiver_rst_q;
    assign rx_busy      = rx_busy_q;
    assign pkt_done_stb = pkt_done_stb_q;
    assign pkt_status   = pkt_status_q;
    assign cnt_ok       = cnt_ok_q;
    assign cnt_fcs_err  = cnt_fcs_err_q;
    assign cnt_abort    = cnt_abort_q;
    assign state        = state_q;

endmodule
